// File: rtl/decode_pkg.sv
// ============================================================================
// decode_pkg : opcode/funct constants, decode enums and helpers for decode_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_J, NPC_JR} npc_sel_e;
  typedef enum logic [2:0] {CMP_NONE, CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ} cmp_op_e;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_op_e;

  function automatic logic [31:0] extend_imm(input ext_op_e op, input logic [15:0] imm);
    case (op)
      EXT_ZERO: extend_imm = {16'h0000, imm};
      EXT_LUI:  extend_imm = {imm, 16'h0000};
      default:  extend_imm = {{16{imm[15]}}, imm};
    endcase
  endfunction

  // Signed comparisons; the zero-compare ops ignore b.
  function automatic logic cmp_eval(input cmp_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      CMP_EQ:  cmp_eval = (a == b);
      CMP_NE:  cmp_eval = (a != b);
      CMP_LEZ: cmp_eval = ($signed(a) <= 0);
      CMP_GTZ: cmp_eval = ($signed(a) > 0);
      CMP_LTZ: cmp_eval = ($signed(a) < 0);
      CMP_GEZ: cmp_eval = ($signed(a) >= 0);
      default: cmp_eval = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_pipe_if.sv
// ============================================================================
// decode_pipe_if : D-stage inputs, W writeback, forwarding and E-stage outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface decode_pipe_if #(
  parameter int NFWD   = 2,
  parameter int FWD_SW = $clog2(NFWD + 1)
) ();

  logic [31:0]        instr_d;
  logic [31:0]        pc4_d;
  logic               valid_d;
  logic               stall_d;
  logic               flush_e;
  logic               wb_we;
  logic [4:0]         wb_addr;
  logic [31:0]        wb_data;
  logic [32*NFWD-1:0] fwd_data;
  logic [FWD_SW-1:0]  fwd_sel_rs;
  logic [FWD_SW-1:0]  fwd_sel_rt;
  logic               redirect;
  logic [31:0]        npc;
  logic [31:0]        instr_e;
  logic [31:0]        rs_e;
  logic [31:0]        rt_e;
  logic [31:0]        imm_e;
  logic [31:0]        pc4_e;
  logic               valid_e;

  modport master (
    output instr_d, pc4_d, valid_d, stall_d, flush_e,
    output wb_we, wb_addr, wb_data, fwd_data, fwd_sel_rs, fwd_sel_rt,
    input  redirect, npc, instr_e, rs_e, rt_e, imm_e, pc4_e, valid_e
  );

  modport slave (
    input  instr_d, pc4_d, valid_d, stall_d, flush_e,
    input  wb_we, wb_addr, wb_data, fwd_data, fwd_sel_rs, fwd_sel_rt,
    output redirect, npc, instr_e, rs_e, rt_e, imm_e, pc4_e, valid_e
  );

endinterface

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// regfile_2r1w : 32x32 register file, 2 read / 1 write, $0 hardwired to zero
//                DECODE_BYPASS_EN: same-cycle write-through to the read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [32];
  logic        wr_active;

  assign wr_active = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: 32'h0};
    end else if (wr_active) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef DECODE_BYPASS_EN
  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];
    if (wr_active && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_active && (waddr == raddr_b)) rdata_b = wdata;
  end
`else
  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/decode_pipe.sv
// ============================================================================
// decode_pipe : MIPS decode stage with N-source forwarding, early branch/jump
//               resolution, immediate extender and D/E pipeline register.
//               Optional macro DECODE_BYPASS_EN (regfile write-through).
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_pipe
  import decode_pkg::*;
#(
  parameter int NFWD   = 2,
  parameter int FWD_SW = $clog2(NFWD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  decode_pipe_if.slave  bus
);

  logic [5:0]  opcode;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] imm16;
  logic [5:0]  funct;
  logic [31:0] rs_rf;
  logic [31:0] rt_rf;
  logic [31:0] rs_f;
  logic [31:0] rt_f;
  logic [31:0] imm_ext;
  logic [31:0] br_target;
  logic [31:0] j_target;
  npc_sel_e    npc_sel;
  cmp_op_e     cmp_op;
  ext_op_e     ext_op;
  logic        is_bgezal;
  logic        taken;
  logic        bubble;

  assign opcode  = bus.instr_d[31:26];
  assign rs_addr = bus.instr_d[25:21];
  assign rt_addr = bus.instr_d[20:16];
  assign imm16   = bus.instr_d[15:0];
  assign funct   = bus.instr_d[5:0];

  regfile_2r1w u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_we),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rs_rf),
    .rdata_b (rt_rf)
  );

  // Select codes above NFWD fall through to the register file value.
  always_comb begin
    rs_f = rs_rf;
    rt_f = rt_rf;
    for (int k = 0; k < NFWD; k++) begin
      if (bus.fwd_sel_rs == FWD_SW'(k + 1)) rs_f = bus.fwd_data[k*32 +: 32];
      if (bus.fwd_sel_rt == FWD_SW'(k + 1)) rt_f = bus.fwd_data[k*32 +: 32];
    end
  end

  always_comb begin
    npc_sel   = NPC_SEQ;
    cmp_op    = CMP_NONE;
    ext_op    = EXT_SIGN;
    is_bgezal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR || funct == FN_JALR) npc_sel = NPC_JR;
      end
      OP_REGIMM: begin
        case (rt_addr)
          RT_BLTZ:   begin npc_sel = NPC_BR; cmp_op = CMP_LTZ; end
          RT_BGEZ:   begin npc_sel = NPC_BR; cmp_op = CMP_GEZ; end
          RT_BGEZAL: begin npc_sel = NPC_BR; cmp_op = CMP_GEZ; is_bgezal = 1'b1; end
          default:   ;
        endcase
      end
      OP_J, OP_JAL: npc_sel = NPC_J;
      OP_BEQ:       begin npc_sel = NPC_BR; cmp_op = CMP_EQ;  end
      OP_BNE:       begin npc_sel = NPC_BR; cmp_op = CMP_NE;  end
      OP_BLEZ:      begin npc_sel = NPC_BR; cmp_op = CMP_LEZ; end
      OP_BGTZ:      begin npc_sel = NPC_BR; cmp_op = CMP_GTZ; end
      OP_ANDI, OP_ORI, OP_XORI: ext_op = EXT_ZERO;
      OP_LUI:       ext_op = EXT_LUI;
      default:      ;
    endcase
  end

  assign imm_ext   = extend_imm(ext_op, imm16);
  assign taken     = cmp_eval(cmp_op, rs_f, rt_f);
  assign br_target = bus.pc4_d + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {bus.pc4_d[31:28], bus.instr_d[25:0], 2'b00};

  // Redirect is suppressed while stalled since forwarded operands may still be stale.
  assign bus.redirect = bus.valid_d && !bus.stall_d &&
                        ((npc_sel == NPC_J) || (npc_sel == NPC_JR) ||
                         ((npc_sel == NPC_BR) && taken));

  always_comb begin
    case (npc_sel)
      NPC_BR:  bus.npc = br_target;
      NPC_J:   bus.npc = j_target;
      NPC_JR:  bus.npc = rs_f;
      default: bus.npc = bus.pc4_d;
    endcase
  end

  // A not-taken bgezal is nullified so the link write never happens.
  assign bubble = bus.flush_e || bus.stall_d || !bus.valid_d || (is_bgezal && !taken);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      bus.instr_e <= 32'h0;
      bus.rs_e    <= 32'h0;
      bus.rt_e    <= 32'h0;
      bus.imm_e   <= 32'h0;
      bus.pc4_e   <= 32'h0;
      bus.valid_e <= 1'b0;
    end else begin
      bus.instr_e <= bus.instr_d;
      bus.rs_e    <= rs_f;
      bus.rt_e    <= rt_f;
      bus.imm_e   <= imm_ext;
      bus.pc4_e   <= bus.pc4_d;
      bus.valid_e <= 1'b1;
    end
  end

endmodule

`default_nettype wire
